// File: rtl/round_controller_pkg.sv
// Shared types and constants for the binary-guess round controller.
package round_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_JUDGE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Galois right-shift taps for x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_SEED = 8'hA5;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return (q >> 1) ^ (q[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/round_controller_lfsr8.sv
// Free-running 8-bit Galois LFSR; steps every clock, reloads SEED on reset.
module lfsr8
    import round_controller_pkg::*;
#(
    parameter logic [7:0] SEED = DEFAULT_SEED
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [7:0] o_q
);

    logic [7:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_q <= SEED;
        else       r_q <= lfsr_next(r_q);
    end

    assign o_q = r_q;

endmodule

// File: rtl/round_controller.sv
// Sequences one binary-guess game: target draw, per-round countdown, judgement, score pulses.
// Submit at edge N gives score_inc in cycle N..N+1 and a new target after edge N+2.
module round_controller
    import round_controller_pkg::*;
#(
    parameter int         TARGET_W    = 8,
    parameter int         ROUNDS      = 10,
    parameter int         ROUND_TICKS = 10,
    parameter logic [7:0] SEED        = DEFAULT_SEED
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_submit,
    input  logic [TARGET_W-1:0] i_guess,
    input  logic                i_tick,
    output logic [TARGET_W-1:0] o_target,
    output logic                o_score_inc,
    output logic                o_score_clr,
    output logic [3:0]          o_round_num,
    output logic [3:0]          o_time_left,
    output logic                o_playing,
    output logic                o_game_over,
    output logic                o_hit
);

    localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);
    localparam logic [3:0] TICKS_L  = 4'(ROUND_TICKS);

    state_t              r_state;
    state_t              w_next_state;
    logic [7:0]          w_lfsr;
    logic [TARGET_W-1:0] w_lfsr_t;
    logic                w_start_ok;

    logic [TARGET_W-1:0] r_target;
    logic [TARGET_W-1:0] r_guess;
    logic                r_timeout;
    logic                r_score_inc;
    logic                r_score_clr;
    logic [3:0]          r_round_num;
    logic [3:0]          r_time_left;
    logic                r_hit;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .o_q   (w_lfsr)
    );

    generate
        if (TARGET_W > 8) begin : g_wide
            assign w_lfsr_t = {{(TARGET_W-8){1'b0}}, w_lfsr};
        end else if (TARGET_W == 8) begin : g_exact
            assign w_lfsr_t = w_lfsr;
        end else begin : g_narrow
            assign w_lfsr_t = w_lfsr[TARGET_W-1:0];
        end
    endgenerate

    assign w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (i_start) w_next_state = ST_LOAD;
            ST_LOAD:          w_next_state = ST_PLAY;
            ST_PLAY: begin
                if (i_submit)                            w_next_state = ST_JUDGE;
                else if (i_tick && r_time_left == 4'd1)  w_next_state = ST_JUDGE;
            end
            ST_JUDGE: w_next_state = (r_round_num == ROUNDS_L) ? ST_DONE : ST_LOAD;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_target    <= '0;
            r_guess     <= '0;
            r_timeout   <= 1'b0;
            r_score_inc <= 1'b0;
            r_score_clr <= 1'b0;
            r_round_num <= 4'd0;
            r_time_left <= 4'd0;
            r_hit       <= 1'b0;
        end else begin
            r_score_clr <= w_start_ok;
            r_score_inc <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_round_num <= 4'd0;
                        r_hit       <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_target    <= w_lfsr_t;
                    r_time_left <= TICKS_L;
                    r_round_num <= r_round_num + 4'd1;
                end
                ST_PLAY: begin
                    // score_inc is decided here so it is already high during JUDGE
                    if (i_submit) begin
                        r_guess     <= i_guess;
                        r_timeout   <= 1'b0;
                        r_score_inc <= (i_guess == r_target);
                    end else if (i_tick) begin
                        r_time_left <= r_time_left - 4'd1;
                        if (r_time_left == 4'd1) r_timeout <= 1'b1;
                    end
                end
                ST_JUDGE: r_hit <= (r_guess == r_target) && !r_timeout;
                default: ;
            endcase
        end
    end

    assign o_target    = r_target;
    assign o_score_inc = r_score_inc;
    assign o_score_clr = r_score_clr;
    assign o_round_num = r_round_num;
    assign o_time_left = r_time_left;
    assign o_playing   = (r_state == ST_PLAY);
    assign o_game_over = (r_state == ST_DONE);
    assign o_hit       = r_hit;

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
Sequences one game of the binary-guess game: draws a pseudo-random target, runs a per-round countdown, judges the player's switch value on submit, and pulses the score increment.
- Sits between the debounced button/switch inputs and the score counter.
- `score_inc` drives the counter's `is_equal`.
- `score_clr` is OR'ed into the counter's `rst`.
- `target`, `round_num` and `time_left` feed the display logic.

Parameters:
- TARGET_W, 8, width of target and guess.
- ROUNDS, 10, rounds per game (1..15).
- ROUND_TICKS, 10, tick pulses allowed per round (1..15).
- SEED, 8'hA5, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse (debounced button): begin a game.
- submit  in  1  one-cycle pulse (debounced button): lock in a guess.
- guess  in  TARGET_W  player switch value.
- tick  in  1  one-cycle enable, nominally 1 Hz.
- target  out  TARGET_W  current round's target.
- score_inc  out  1  one-cycle pulse on a correct guess.
- score_clr  out  1  one-cycle pulse when a game starts.
- round_num  out  4  current round, 1..ROUNDS; 0 in IDLE.
- time_left  out  4  remaining ticks in the round.
- playing  out  1  high while in PLAY.
- game_over  out  1  high in DONE.
- hit  out  1  result of the last judged round; held until the next judgement.

Behaviour:
- Synchronous active-high reset applies on the next edge. All outputs go to 0, state = IDLE, LFSR = SEED. Reset mid-game aborts immediately.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1.
  - Steps every clock in every state, including IDLE.
  - Never reaches 0.
  - target = low TARGET_W bits of the LFSR (zero-extended if TARGET_W > 8).
- States: IDLE, LOAD, PLAY, JUDGE, DONE.
- IDLE:
  - start=1 → LOAD. On the same edge: round_num <= 0, game_over <= 0, hit <= 0.
  - score_clr is high for the one cycle following that edge.
- LOAD (exactly 1 cycle):
  - target <= LFSR value.
  - time_left <= ROUND_TICKS.
  - round_num <= round_num + 1.
  - → PLAY.
- PLAY (playing=1):
  - submit=1: latch guess, timeout flag <= 0, → JUDGE.
  - else tick=1 with time_left==1: time_left <= 0, timeout flag <= 1, → JUDGE.
  - else tick=1: time_left decrements by 1.
  - submit and tick in the same cycle: submit wins, and time_left is not decremented.
  - start is ignored.
- JUDGE (exactly 1 cycle):
  - score_inc = (latched guess == target) && !timeout, registered so it is high for exactly this cycle.
  - hit <= the same value.
  - round_num == ROUNDS → DONE; otherwise → LOAD.
- Latency:
  - submit sampled at edge N → score_inc high in cycle N..N+1.
  - New target visible after edge N+2.
- DONE:
  - game_over=1; target, round_num and hit hold.
  - start=1 → LOAD, with the same clears and score_clr pulse as from IDLE.
- Widths:
  - time_left and round_num are 4-bit and never wrap: round_num ≤ ROUNDS ≤ 15, and time_left never decrements below 0.
- Only a single score_inc pulse occurs per round, so the 4-bit score counter cannot exceed 15 when ROUNDS ≤ 15.

Decomposition:
- Shared package holds:
  - State enum: IDLE=0, LOAD=1, PLAY=2, JUDGE=3, DONE=4; 3 bits.
  - LFSR tap constant 8'hB8.
  - Default SEED.
- One sub-module: `lfsr8` (clk, rst, seed parameter, 8-bit q, free-running).
- FSM, round/tick counters and output registers live in `round_controller`.

Test Plan (ROUNDS=3, ROUND_TICKS=4, SEED=8'hA5):
- rst mid-PLAY in round 2 → next cycle: state IDLE, all outputs 0, LFSR=A5; later start pulse → round_num=1, score_clr pulse.
- start; in each round, submit with guess=target → score_inc one-cycle pulse ×3; hit=1; game_over=1 after round 3; round_num holds 3.
- start; round 1: guess=target^1 then submit → score_inc stays 0, hit=0; advances to round_num=2.
- start; no submit, 4 tick pulses → time_left 4→3→2→1→0; JUDGE with score_inc=0 on the 4th tick; next round loads time_left=4.
- In PLAY with time_left=2: submit and tick in the same cycle with guess=target → score_inc=1, time_left stays 2 until LOAD.
- start pulses during PLAY/JUDGE ignored; start in DONE → score_clr pulse, round_num=1, new target ≠ 0, game_over=0.
